modulation_controller: RTL

- Sequences the modulation sampler path: accepts new modulation configurations (cycle, update period, RAM bank, start time) over a valid/ready handshake.
- Starts playback at an absolute SYS_TIME.
- Commits mid-run configuration changes only at a sampler wrap boundary, so a pattern is never cut partway through.
- Sits between the CPU-side register file and the sampler/modulation RAM. It drives the sampler's MOD_CYCLE and UPDATE_CYCLE inputs and the RAM bank select.

---
 rtl/mod_ctrl_pkg.sv | 28 ++
 rtl/mod_cfg_shadow.sv | 27 ++
 rtl/modulation_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mod_ctrl_pkg.sv
// Shared types and reset constants for the modulation controller.
// Build option: MOD_CTRL_TIMEOUT_EN (see modulation_controller.sv).
package mod_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PEND  = 3'd3,
    S_DRAIN = 3'd4
  } mod_state_t;

  typedef struct packed {
    logic [15:0] mod_cycle;
    logic [31:0] update_cycle;
    logic        bank;
  } mod_cfg_t;

  localparam logic [15:0] DEF_MOD_CYCLE      = 16'd0;
  localparam logic [31:0] DEF_UPDATE_CYCLE   = 32'd40960;
  localparam logic [31:0] DEF_MIN_UPDATE     = 32'd2;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd1048576;

  function automatic logic [31:0] clamp_update(input logic [31:0] v, input logic [31:0] lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/mod_cfg_shadow.sv
// Single-entry shadow register holding a configuration that waits for a wrap boundary.
module mod_cfg_shadow
  import mod_ctrl_pkg::*;
(
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     load,
  input  logic     clear,
  input  mod_cfg_t d,
  output mod_cfg_t q,
  output logic     vld
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (clear) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end
  end

endmodule

// File: rtl/modulation_controller.sv
// Modulation sampler sequencer: timed start, wrap-aligned config commit, wrap-aligned stop.
// Build option: define MOD_CTRL_TIMEOUT_EN to force PEND/DRAIN transitions after TIMEOUT_CYCLES.
module modulation_controller
  import mod_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_MOD_CYCLE    = DEF_MOD_CYCLE,
  parameter logic [31:0] RESET_UPDATE_CYCLE = DEF_UPDATE_CYCLE,
  parameter logic [31:0] MIN_UPDATE_CYCLE   = DEF_MIN_UPDATE,
  parameter logic [31:0] TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [63:0] SYS_TIME,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [15:0] CFG_MOD_CYCLE,
  input  logic [31:0] CFG_UPDATE_CYCLE,
  input  logic        CFG_BANK,
  input  logic [63:0] CFG_START_TIME,
  input  logic        STOP_REQ,
  input  logic        SMP_UPDATE,
  input  logic [15:0] SMP_ADDR,
  output logic [15:0] MOD_CYCLE,
  output logic [31:0] UPDATE_CYCLE,
  output logic        BANK,
  output logic        RUN,
  output logic        COMMIT,
  output logic        BUSY
);

  mod_state_t  state_q, state_d;
  mod_cfg_t    act_q, cfg_in, shd_q;
  logic [63:0] start_q;
  logic        run_q, commit_q, shd_vld;
  logic        wrap, xfer, to_hit;
  logic        load_act, take_shd, set_run, clr_run, shd_load, shd_clear, pulse;

  assign wrap      = SMP_UPDATE && (SMP_ADDR == act_q.mod_cycle);
  assign CFG_READY = ((state_q == S_IDLE) || (state_q == S_RUN)) && !STOP_REQ;
  assign xfer      = CFG_VALID && CFG_READY;
  assign cfg_in    = '{mod_cycle:    CFG_MOD_CYCLE,
                       update_cycle: clamp_update(CFG_UPDATE_CYCLE, MIN_UPDATE_CYCLE),
                       bank:         CFG_BANK};

`ifdef MOD_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Counts cycles spent in PEND/DRAIN; restarts on every state change.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt <= '0;
    end else if ((state_d != state_q) || ((state_q != S_PEND) && (state_q != S_DRAIN))) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  assign to_hit = (to_cnt == (TIMEOUT_CYCLES - 32'd1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    load_act  = 1'b0;
    take_shd  = 1'b0;
    set_run   = 1'b0;
    clr_run   = 1'b0;
    shd_load  = 1'b0;
    shd_clear = 1'b0;
    pulse     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          load_act = 1'b1;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: begin
        if (STOP_REQ) begin
          state_d = S_IDLE;
        end else if (SYS_TIME >= start_q) begin
          set_run = 1'b1;
          pulse   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (STOP_REQ) begin
          state_d = S_DRAIN;
        end else if (xfer) begin
          shd_load = 1'b1;
          state_d  = S_PEND;
        end
      end
      S_PEND: begin
        // A stop landing on a wrap ends playback there instead of committing.
        if (STOP_REQ && wrap) begin
          clr_run   = 1'b1;
          shd_clear = 1'b1;
          state_d   = S_IDLE;
        end else if (STOP_REQ) begin
          shd_clear = 1'b1;
          state_d   = S_DRAIN;
        end else if ((wrap || to_hit) && shd_vld) begin
          take_shd  = 1'b1;
          shd_clear = 1'b1;
          pulse     = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_DRAIN: begin
        if (wrap || to_hit) begin
          clr_run = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      act_q    <= '{mod_cycle: RESET_MOD_CYCLE, update_cycle: RESET_UPDATE_CYCLE, bank: 1'b0};
      start_q  <= '0;
      run_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= pulse;
      if (load_act) begin
        act_q   <= cfg_in;
        start_q <= CFG_START_TIME;
      end else if (take_shd) begin
        act_q <= shd_q;
      end
      if (set_run) begin
        run_q <= 1'b1;
      end else if (clr_run) begin
        run_q <= 1'b0;
      end
    end
  end

  mod_cfg_shadow u_shadow (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (shd_load),
    .clear (shd_clear),
    .d     (cfg_in),
    .q     (shd_q),
    .vld   (shd_vld)
  );

  assign MOD_CYCLE    = act_q.mod_cycle;
  assign UPDATE_CYCLE = act_q.update_cycle;
  assign BANK         = act_q.bank;
  assign RUN          = run_q;
  assign COMMIT       = commit_q;
  assign BUSY         = (state_q != S_IDLE);

endmodule
